// File: rtl/uart_xfer_ctrl.sv
// UART loopback transfer sequencer: packs received bytes into memory words, then replays them to the transmitter.
// Optional received-byte checksum enabled by defining UART_CKSUM_EN.
module uart_xfer_ctrl #(
    parameter int NUM_WORDS = 25,
    parameter int ADDR_W    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              mem2uart,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    output logic              recv_done,
    output logic              send_done,
    output logic              IRQ,
    output logic [7:0]        cksum
);

    localparam logic [2:0] ST_RECV     = 3'd0;
    localparam logic [2:0] ST_RX_FULL  = 3'd1;
    localparam logic [2:0] ST_RD_REQ   = 3'd2;
    localparam logic [2:0] ST_RD_WAIT  = 3'd3;
    localparam logic [2:0] ST_TX_ISSUE = 3'd4;
    localparam logic [2:0] ST_TX_WAIT  = 3'd5;
    localparam logic [2:0] ST_DONE     = 3'd6;

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_WORDS - 1);

    logic [2:0]        state;
    logic [1:0]        byte_cnt;
    logic [ADDR_W-1:0] word_cnt;
    logic [23:0]       lanes;
    logic [31:0]       send_reg;
    logic              rx_last;
    logic              rx_accept;

    // The cycle that writes the final word is spent announcing completion, so no byte is taken then.
    assign rx_accept = (state == ST_RECV) && !rx_last && rx_valid;

    // NOTE: every register here uses non-blocking assignment so all state updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_RECV;
            byte_cnt  <= '0;
            word_cnt  <= '0;
            lanes     <= '0;
            send_reg  <= '0;
            rx_last   <= 1'b0;
            tx_start  <= 1'b0;
            tx_data   <= '0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            mem_re    <= 1'b0;
            recv_done <= 1'b0;
            send_done <= 1'b0;
            IRQ       <= 1'b0;
        end else begin
            // NOTE: strobes default low each cycle; only the branch that fires raises one for a single cycle.
            mem_we   <= 1'b0;
            mem_re   <= 1'b0;
            tx_start <= 1'b0;
            IRQ      <= 1'b0;

            case (state)
                ST_RECV: begin
                    if (rx_last) begin
                        rx_last   <= 1'b0;
                        recv_done <= 1'b1;
                        IRQ       <= 1'b1;
                        state     <= ST_RX_FULL;
                    end else if (rx_accept) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= word_cnt;
                            mem_wdata <= {rx_data, lanes};
                            word_cnt  <= word_cnt + 1'b1;
                            rx_last   <= (word_cnt == LAST_WORD);
                        end else begin
                            lanes[{byte_cnt, 3'b000} +: 8] <= rx_data;
                        end
                    end
                end

                ST_RX_FULL: begin
                    if (mem2uart) begin
                        word_cnt <= '0;
                        mem_re   <= 1'b1;
                        mem_addr <= '0;
                        state    <= ST_RD_REQ;
                    end
                end

                ST_RD_REQ: state <= ST_RD_WAIT;

                ST_RD_WAIT: begin
                    send_reg <= mem_rdata;
                    byte_cnt <= '0;
                    state    <= ST_TX_ISSUE;
                end

                ST_TX_ISSUE: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= send_reg[{byte_cnt, 3'b000} +: 8];
                        state    <= ST_TX_WAIT;
                    end
                end

                ST_TX_WAIT: begin
                    // tx_busy only rises the cycle after tx_start, so the pulse cycle itself is skipped.
                    if (!tx_start && !tx_busy) begin
                        if (byte_cnt != 2'd3) begin
                            byte_cnt <= byte_cnt + 2'd1;
                            state    <= ST_TX_ISSUE;
                        end else if (word_cnt < LAST_WORD) begin
                            word_cnt <= word_cnt + 1'b1;
                            mem_re   <= 1'b1;
                            mem_addr <= word_cnt + 1'b1;
                            state    <= ST_RD_REQ;
                        end else begin
                            send_done <= 1'b1;
                            IRQ       <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    if (!mem2uart) begin
                        recv_done <= 1'b0;
                        send_done <= 1'b0;
                        word_cnt  <= '0;
                        byte_cnt  <= '0;
                        state     <= ST_RECV;
                    end
                end

                default: state <= ST_RECV;
            endcase
        end
    end

`ifdef UART_CKSUM_EN
    logic [7:0] cksum_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cksum_q <= '0;
        end else if (state == ST_DONE && !mem2uart) begin
            cksum_q <= '0;
        end else if (rx_accept) begin
            cksum_q <= cksum_q + rx_data;
        end
    end

    assign cksum = cksum_q;
`else
    assign cksum = 8'd0;
`endif

endmodule

// File: tb/tb_uart_xfer_ctrl.sv
// Scoreboard bench for uart_xfer_ctrl: word memory and busy-for-10-cycles transmitter models,
// expected writes and transmitted bytes queued as bytes are driven.
module tb_uart_xfer_ctrl;

    localparam int NUM_WORDS = 25;
    localparam int ADDR_W    = 5;
    localparam int NBYTES    = NUM_WORDS * 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              mem2uart;
    logic              tx_busy;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic              mem_re;
    logic [31:0]       mem_rdata;
    logic              recv_done;
    logic              send_done;
    logic              IRQ;
    logic [7:0]        cksum;

    uart_xfer_ctrl #(.NUM_WORDS(NUM_WORDS), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .mem2uart  (mem2uart),
        .tx_busy   (tx_busy),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .recv_done (recv_done),
        .send_done (send_done),
        .IRQ       (IRQ),
        .cksum     (cksum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t        wr_q[$];
    logic [7:0] tx_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int tx_cnt = 0;
    int re_idx = 0;
    int irq_cnt = 0;
    int last_we_cyc = 0;
    int first_re_cyc = -1;
    int busy_cnt = 0;

    logic [31:0] mem [0:(1<<ADDR_W)-1];
    logic [31:0] asm_word;
    int          asm_cnt;
    int          asm_addr;
    logic [7:0]  cks;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Word memory: read data valid the cycle after mem_re.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    // Transmitter: busy for 10 cycles starting the cycle after tx_start.
    always @(posedge clk) begin
        if (!rst)               busy_cnt <= 0;
        else if (tx_start)      busy_cnt <= 10;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    always @(negedge clk) begin
        if (rst) begin
            if (IRQ) irq_cnt++;
            if (mem_we) begin
                check("we_pending", 32'(wr_q.size() != 0), 32'd1);
                if (wr_q.size() != 0) begin
                    wr_t e;
                    e = wr_q.pop_front();
                    check("we_addr", 32'(mem_addr), 32'(e.addr));
                    check("we_data", mem_wdata, e.data);
                end
                wr_cnt++;
                last_we_cyc = cyc;
            end
            if (mem_re) begin
                check("re_after_full", 32'(wr_cnt), 32'(NUM_WORDS));
                check("re_addr", 32'(mem_addr), 32'(re_idx));
                re_idx++;
                if (first_re_cyc < 0) first_re_cyc = cyc;
            end
            if (tx_start) begin
                check("tx_not_busy", 32'(tx_busy), 32'd0);
                check("tx_after_full", 32'(wr_cnt), 32'(NUM_WORDS));
                check("tx_pending", 32'(tx_q.size() != 0), 32'd1);
                if (tx_q.size() != 0) check("tx_data", 32'(tx_data), 32'(tx_q.pop_front()));
                tx_cnt++;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic begin_xfer();
        wr_q.delete();
        tx_q.delete();
        wr_cnt = 0;
        tx_cnt = 0;
        re_idx = 0;
        irq_cnt = 0;
        first_re_cyc = -1;
        asm_word = '0;
        asm_cnt = 0;
        asm_addr = 0;
        cks = '0;
    endtask

    task automatic rx_byte(input logic [7:0] b, input logic accept);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        if (accept) begin
            asm_word[8*asm_cnt +: 8] = b;
            tx_q.push_back(b);
            cks = cks + b;
            if (asm_cnt == 3) begin
                wr_q.push_back('{addr: ADDR_W'(asm_addr), data: asm_word});
                asm_addr++;
                asm_cnt = 0;
            end else begin
                asm_cnt++;
            end
        end
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_send_done(input int budget, input logic inject);
        int k = 0;
        while (send_done !== 1'b1 && k < budget) begin
            if (inject && (k == 100 || k == 700)) begin
                rx_valid = 1'b1;
                rx_data  = 8'hEE;
            end
            @(negedge clk);
            rx_valid = 1'b0;
            k++;
        end
        check("send_done_seen", 32'(send_done), 32'd1);
    endtask

    task automatic wait_tx(input int n, input int budget);
        int k = 0;
        while (tx_cnt < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("tx_reached", 32'(tx_cnt), 32'(n));
    endtask

    task automatic check_idle(input string pfx);
        check({pfx, "_tx_start"},  32'(tx_start),  32'd0);
        check({pfx, "_tx_data"},   32'(tx_data),   32'd0);
        check({pfx, "_mem_addr"},  32'(mem_addr),  32'd0);
        check({pfx, "_mem_we"},    32'(mem_we),    32'd0);
        check({pfx, "_mem_wdata"}, mem_wdata,      32'd0);
        check({pfx, "_mem_re"},    32'(mem_re),    32'd0);
        check({pfx, "_recv_done"}, 32'(recv_done), 32'd0);
        check({pfx, "_send_done"}, 32'(send_done), 32'd0);
        check({pfx, "_irq"},       32'(IRQ),       32'd0);
        check({pfx, "_cksum"},     32'(cksum),     32'd0);
    endtask

    function automatic logic [7:0] exp_cksum();
`ifdef UART_CKSUM_EN
        return cks;
`else
        return 8'd0;
`endif
    endfunction

    initial begin
        rst      = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        mem2uart = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b1;

        // Transfer A: ascending bytes, send requested after reception completes.
        begin_xfer();
        for (int i = 0; i < NBYTES; i++) rx_byte(8'(i), 1'b1);
        repeat (2) @(negedge clk);
        check("a_writes",    32'(wr_cnt),    32'(NUM_WORDS));
        check("a_recv_done", 32'(recv_done), 32'd1);
        check("a_send_done", 32'(send_done), 32'd0);
        check("a_irq_recv",  32'(irq_cnt),   32'd1);
        check("a_mem0",      mem[0],         32'h0302_0100);
        check("a_mem24",     mem[24],        32'h6362_6160);
        check("a_cksum",     32'(cksum),     32'(exp_cksum()));

        for (int i = 0; i < 3; i++) rx_byte(8'hAA, 1'b0);
        check("a_full_writes", 32'(wr_cnt), 32'(NUM_WORDS));
        check("a_full_mem0",   mem[0],      32'h0302_0100);
        check("a_full_cksum",  32'(cksum),  32'(exp_cksum()));

        mem2uart = 1'b1;
        wait_send_done(3000, 1'b1);
        @(negedge clk);
        check("a_tx_count",  32'(tx_cnt),      32'(NBYTES));
        check("a_tx_left",   32'(tx_q.size()), 32'd0);
        check("a_irq_send",  32'(irq_cnt),     32'd2);
        check("a_done_recv", 32'(recv_done),   32'd1);
        check("a_done_send", 32'(send_done),   32'd1);
        check("a_tx_writes", 32'(wr_cnt),      32'(NUM_WORDS));
        check("a_tx_cksum",  32'(cksum),       32'(exp_cksum()));
        check("a_tx_mem24",  mem[24],          32'h6362_6160);

        mem2uart = 1'b0;
        repeat (2) @(negedge clk);
        check("a_clr_recv",  32'(recv_done), 32'd0);
        check("a_clr_send",  32'(send_done), 32'd0);
        check("a_clr_irq",   32'(irq_cnt),   32'd2);
        check("a_clr_cksum", 32'(cksum),     32'd0);

        // Transfer B: send requested after 40 bytes; must wait for the full buffer.
        begin_xfer();
        for (int i = 0; i < 40; i++) rx_byte(8'(i) ^ 8'h5A, 1'b1);
        mem2uart = 1'b1;
        for (int i = 40; i < NBYTES; i++) rx_byte(8'(i) ^ 8'h5A, 1'b1);
        wait_send_done(3000, 1'b0);
        @(negedge clk);
        check("b_tx_count", 32'(tx_cnt),                    32'(NBYTES));
        check("b_latency",  32'(first_re_cyc - last_we_cyc), 32'd2);
        check("b_irq",      32'(irq_cnt),                   32'd2);
        mem2uart = 1'b0;
        repeat (2) @(negedge clk);
        check("b_clr_recv", 32'(recv_done), 32'd0);

        // Transfer C: reset during the 50th transmitted byte.
        begin_xfer();
        for (int i = 0; i < NBYTES; i++) rx_byte(8'(i * 7 + 3), 1'b1);
        mem2uart = 1'b1;
        wait_tx(50, 2000);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("midrst");
        @(negedge clk);
        mem2uart = 1'b0;
        rst = 1'b1;
        begin_xfer();
        rx_byte(8'h11, 1'b1);
        rx_byte(8'h22, 1'b1);
        rx_byte(8'h33, 1'b1);
        rx_byte(8'h44, 1'b1);
        repeat (2) @(negedge clk);
        check("c_writes",    32'(wr_cnt),    32'd1);
        check("c_mem0",      mem[0],         32'h4433_2211);
        check("c_no_tx",     32'(tx_cnt),    32'd0);
        check("c_recv_done", 32'(recv_done), 32'd0);
        check("c_cksum",     32'(cksum),     32'(exp_cksum()));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_xfer_ctrl.md
Name: uart_xfer_ctrl

Overview:
- Sequences the UART loopback datapath.
- Receive phase: packs bytes from the UART receiver little-endian into 32-bit words and writes NUM_WORDS words to data memory.
- Send phase: on the mem2uart request, reads the words back and feeds them byte-by-byte to the UART transmitter.
- Sits between the UART RX/TX cores and the word memory inside TOP; drives recv_done, send_done and IRQ.

Parameters:
NUM_WORDS, 25, words per transfer (100 bytes)
ADDR_W, 5, memory word-address width; 2**ADDR_W >= NUM_WORDS

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-low reset (0 = reset, sampled on rising clk)
rx_valid  in  1  one-cycle pulse, rx_data holds a received byte
rx_data  in  8  received byte
mem2uart  in  1  level request to start the send phase
tx_busy  in  1  transmitter busy; rises the cycle after tx_start, falls after the stop bit
tx_start  out  1  one-cycle pulse, load tx_data into the transmitter
tx_data  out  8  byte to transmit
mem_addr  out  ADDR_W  word address
mem_we  out  1  one-cycle write strobe
mem_wdata  out  32  write word
mem_re  out  1  one-cycle read strobe
mem_rdata  in  32  read word, valid exactly 1 cycle after mem_re
recv_done  out  1  all NUM_WORDS words written
send_done  out  1  all bytes handed to TX and TX idle
IRQ  out  1  one-cycle pulse on recv_done rise and on send_done rise
cksum  out  8  received-byte checksum (see Optional Feature)

Behaviour:
- Reset (rst=0 at a clk edge): state RECV; word and byte counters cleared; all outputs 0. Reset mid-transfer aborts with no further strobes.
- States: RECV -> RX_FULL -> RD_REQ -> RD_WAIT -> TX_ISSUE -> TX_WAIT -> (TX_ISSUE | RD_REQ | DONE) -> RECV.
- RECV:
  - Each rx_valid stores rx_data into byte lane byte_cnt (byte 0 -> bits[7:0]); byte_cnt increments mod 4.
  - On the 4th byte: next cycle, mem_we=1, mem_addr=word_cnt, mem_wdata={rx_data, lanes 2..0}; word_cnt increments.
  - On the write of word NUM_WORDS-1: the following cycle recv_done=1, IRQ pulses, state goes to RX_FULL.
- rx_valid is ignored outside RECV (no write, no counter change).
- mem2uart is ignored outside RX_FULL. If it is already high when RX_FULL is entered, the send starts the next cycle.
- RX_FULL: wait for mem2uart=1; then clear word_cnt and go to RD_REQ.
- RD_REQ: mem_re=1, mem_addr=word_cnt, for one cycle.
- RD_WAIT: latch mem_rdata into the send register; byte_cnt=0.
- TX_ISSUE: when tx_busy=0, pulse tx_start with tx_data = send register byte lane byte_cnt; go to TX_WAIT.
- TX_WAIT:
  - Ignore tx_busy for the first cycle, then wait for tx_busy=0.
  - byte_cnt<3: byte_cnt++, go to TX_ISSUE.
  - byte_cnt=3 and word_cnt<NUM_WORDS-1: word_cnt++, go to RD_REQ.
  - Otherwise: go to DONE, send_done=1, IRQ pulses.
- DONE: hold recv_done=1 and send_done=1 until mem2uart=0. Then clear both flags and all counters and return to RECV for the next transfer.
- tx_data holds its value until the next tx_start; mem_addr holds its last value; mem_wdata is don't-care when mem_we=0.
- Exactly one tx_start per byte: NUM_WORDS*4 pulses per send phase, in ascending address and lane order.

Optional Feature:
- Macro: UART_CKSUM_EN.
- Defined:
  - cksum = 8-bit wrapping sum of all bytes accepted in RECV.
  - Cleared on reset and on the DONE->RECV transition; frozen outside RECV.
- Undefined: cksum tied to 0 and no adder is synthesized.

Test Plan:
- Reset, then 100 rx_valid pulses with bytes 0x00..0x63 -> 25 mem_we pulses. Word 0 = 0x03020100, word 24 = 0x63626160 at addr 24. recv_done rises after the last write, with one IRQ pulse.
- Then mem2uart=1 with a TX model (busy 10 cycles per byte) -> 100 tx_start pulses carrying 0x00..0x63 in order. No tx_start while tx_busy=1. send_done=1 with one IRQ; mem2uart=0 -> recv_done=send_done=0.
- mem2uart=1 asserted after only 40 bytes -> no mem_re or tx_start until the 100th byte. Send begins the cycle after RX_FULL.
- rst=0 asserted during the 50th tx byte -> next cycle all outputs 0. After release, 4 new bytes produce a write at addr 0.
- Extra rx_valid pulses while in RX_FULL or TX states -> no mem_we; memory contents unchanged.
- UART_CKSUM_EN defined, bytes 0x00..0x63 -> cksum = 0x56 (4950 mod 256). Undefined -> cksum = 0.
